text_console_writer: RTL and testbench

Character-stream front end that fills the 80×30 text VRAM scanned by the video generator. It accepts ASCII bytes over a valid/ready handshake and writes `{attr, char}` words at the cursor position. It interprets the control codes CR, LF, BS and FF, and scrolls the screen when the cursor moves past the last row. It owns the VRAM write port and a read port used only during scrolling.

---
 rtl/text_console_writer.sv | 209 ++++++++++++++++++++
 tb/tb_text_console_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// text_console_writer: turns an ASCII byte stream into {attr, char} writes
// on the 80x30 text VRAM. It handles CR, LF, BS and FF and owns the VRAM ports.
// Optional feature macro: TEXT_CONSOLE_SCROLL_EN. When it is defined, a row
// advance past the last row scrolls the screen up by one row. When it is not
// defined, the cursor wraps back to row 0 and old text is overwritten in place.
module text_console_writer #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [7:0] DEFAULT_ATTR = 8'h07,
    parameter logic [7:0] BLANK_CHAR   = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  attr_data,
    input  logic        attr_we,
    output logic [15:0] vram_addr,
    output logic [15:0] vram_wdata,
    output logic        vram_we,
    input  logic [15:0] vram_rdata,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    localparam logic [15:0] COLS_W    = 16'(COLS);
    localparam logic [15:0] LAST_ADDR = 16'(COLS * ROWS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam logic [15:0] COPY_LEN  = 16'(COLS * (ROWS - 1));
`endif

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
`ifdef TEXT_CONSOLE_SCROLL_EN
        SCROLL_RD,
        SCROLL_WR,
`endif
        CLEAR
    } state_e;

    state_e      state_q;
    logic [7:0]  attr_q;
    logic [6:0]  cursorX_q;
    logic [4:0]  cursorY_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        busy_q;
`ifdef TEXT_CONSOLE_SCROLL_EN
    logic [15:0] idx_q;
`endif

    logic [7:0]  attrEff;
    logic        accept;
    logic        lastRow;
    logic [15:0] cursorAddr;
    logic [4:0]  rowAdv_d;

    // An attribute load in the same cycle as an accept applies to that byte.
    assign attrEff    = attr_we ? attr_data : attr_q;
    assign in_ready   = (state_q == IDLE) && rst_n;
    assign accept     = in_valid && in_ready;
    assign lastRow    = (cursorY_q == LAST_ROW);
    assign cursorAddr = 16'(cursorY_q) * COLS_W + 16'(cursorX_q);

`ifdef TEXT_CONSOLE_SCROLL_EN
    // On the last row the cursor stays put; the scroll moves the text instead.
    assign rowAdv_d = lastRow ? cursorY_q : cursorY_q + 5'd1;
    // The copy phase writes the word read in the previous cycle straight through;
    // the final blank-row fill uses the registered word.
    assign vram_wdata = ((state_q == SCROLL_WR) && (idx_q < COPY_LEN)) ? vram_rdata : wdata_q;
`else
    logic unusedRdata;
    assign unusedRdata = ^vram_rdata;
    assign rowAdv_d    = lastRow ? 5'd0 : cursorY_q + 5'd1;
    assign vram_wdata  = wdata_q;
`endif

    assign vram_addr = addr_q;
    assign vram_we   = we_q;
    assign cursor_x  = cursorX_q;
    assign cursor_y  = cursorY_q;
    assign busy      = busy_q;

    // Control FSM: decodes bytes, moves the cursor and sequences VRAM writes, scroll and clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            attr_q    <= DEFAULT_ATTR;
            cursorX_q <= '0;
            cursorY_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TEXT_CONSOLE_SCROLL_EN
            idx_q     <= '0;
`endif
        end else begin
            if (attr_we) begin
                attr_q <= attr_data;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (in_data)
                            CH_CR: cursorX_q <= '0;
                            CH_BS: begin
                                if (cursorX_q != 7'd0) begin
                                    cursorX_q <= cursorX_q - 7'd1;
                                end
                            end
                            CH_LF: begin
                                cursorX_q <= '0;
                                cursorY_q <= rowAdv_d;
`ifdef TEXT_CONSOLE_SCROLL_EN
                                if (lastRow) begin
                                    state_q <= SCROLL_RD;
                                    addr_q  <= COLS_W;
                                    idx_q   <= '0;
                                    busy_q  <= 1'b1;
                                end
`endif
                            end
                            CH_FF: begin
                                state_q <= CLEAR;
                                addr_q  <= '0;
                                wdata_q <= {attrEff, BLANK_CHAR};
                                we_q    <= 1'b1;
                                busy_q  <= 1'b1;
                            end
                            default: begin
                                state_q <= WRITE;
                                addr_q  <= cursorAddr;
                                wdata_q <= {attrEff, in_data};
                                we_q    <= 1'b1;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                    if (cursorX_q == LAST_COL) begin
                        cursorX_q <= '0;
                        cursorY_q <= rowAdv_d;
`ifdef TEXT_CONSOLE_SCROLL_EN
                        if (lastRow) begin
                            state_q <= SCROLL_RD;
                            addr_q  <= COLS_W;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end
`endif
                    end else begin
                        cursorX_q <= cursorX_q + 7'd1;
                    end
                end
`ifdef TEXT_CONSOLE_SCROLL_EN
                SCROLL_RD: begin
                    addr_q  <= idx_q;
                    we_q    <= 1'b1;
                    state_q <= SCROLL_WR;
                end
                SCROLL_WR: begin
                    if (idx_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (idx_q < COPY_LEN - 16'd1) begin
                        idx_q   <= idx_q + 16'd1;
                        addr_q  <= idx_q + 16'd1 + COLS_W;
                        we_q    <= 1'b0;
                        state_q <= SCROLL_RD;
                    end else begin
                        idx_q   <= idx_q + 16'd1;
                        addr_q  <= idx_q + 16'd1;
                        wdata_q <= {attrEff, BLANK_CHAR};
                    end
                end
`endif
                CLEAR: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q   <= IDLE;
                        we_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        cursorX_q <= '0;
                        cursorY_q <= '0;
                    end else begin
                        addr_q  <= addr_q + 16'd1;
                        wdata_q <= {attrEff, BLANK_CHAR};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: table vectors, directed multi-cycle sequences and a
// randomized byte stream checked against a screen-array model of the console.
module tb_text_console_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  attr_data;
    logic        attr_we;
    logic [15:0] vram_addr;
    logic [15:0] vram_wdata;
    logic        vram_we;
    logic [15:0] vram_rdata;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    text_console_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .attr_data  (attr_data),
        .attr_we    (attr_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_rdata (vram_rdata),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model with one-cycle read latency, plus write and busy-cycle counters.
    logic [15:0] vram [0:CELLS-1];
    int writeCnt = 0;
    int busyCnt  = 0;
    always @(posedge clk) begin
        if (vram_we) begin
            if (vram_addr < 16'(CELLS)) vram[vram_addr] <= vram_wdata;
            writeCnt <= writeCnt + 1;
        end
        vram_rdata <= (vram_addr < 16'(CELLS)) ? vram[vram_addr] : 16'hDEAD;
        if (busy) busyCnt <= busyCnt + 1;
    end

    int checkCount = 0;
    int passCount  = 0;

    // Reference screen: what the console should show after each byte.
    logic [15:0] refMem [0:CELLS-1];
    int          refX = 0;
    int          refY = 0;
    logic [7:0]  refAttr = 8'h07;

    typedef struct {
        logic [7:0]  ch;
        logic        expWr;
        logic [15:0] expAddr;
        logic [6:0]  expX;
        logic [4:0]  expY;
    } vec_t;
    vec_t vecs[$];

    task automatic finishRun();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic compareImage(input string name);
        int bad = 0;
        int firstBad = -1;
        for (int i = 0; i < CELLS; i++) begin
            if (vram[i] !== refMem[i]) begin
                if (firstBad < 0) firstBad = i;
                bad++;
            end
        end
        checkCount++;
        if (bad == 0) passCount++;
        else $display("[TB] FAIL %s: %0d cells differ, first at %0d got 0x%h expected 0x%h",
                      name, bad, firstBad, vram[firstBad], refMem[firstBad]);
    endtask

    function automatic void modelRowAdvance();
        if (refY < ROWS - 1) begin
            refY++;
        end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
            for (int i = 0; i < CELLS - COLS; i++) refMem[i] = refMem[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++) refMem[i] = {refAttr, 8'h20};
`else
            refY = 0;
`endif
        end
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        case (b)
            8'h0D: refX = 0;
            8'h08: if (refX > 0) refX--;
            8'h0A: begin
                refX = 0;
                modelRowAdvance();
            end
            8'h0C: begin
                for (int i = 0; i < CELLS; i++) refMem[i] = {refAttr, 8'h20};
                refX = 0;
                refY = 0;
            end
            default: begin
                refMem[refY * COLS + refX] = {refAttr, b};
                if (refX == COLS - 1) begin
                    refX = 0;
                    modelRowAdvance();
                end else begin
                    refX++;
                end
            end
        endcase
    endfunction

    task automatic waitReady(input int maxCycles);
        int n = 0;
        while (!in_ready && n < maxCycles) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checkCount++;
            $display("[TB] FAIL readyTimeout: in_ready=%0b after %0d cycles, expected 1", in_ready, maxCycles);
            finishRun();
        end
    endtask

    // Offers one byte, returns #1 after the accepting edge (cycle N+1).
    task automatic applyStimulus(input logic [7:0] b, input logic doAttr, input logic [7:0] a);
        waitReady(6000);
        in_data   = b;
        in_valid  = 1'b1;
        attr_we   = doAttr;
        attr_data = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        attr_we  = 1'b0;
        if (doAttr) refAttr = a;
        modelByte(b);
    endtask

    task automatic checkCursor(input string name, input int x, input int y);
        checkOutput({name, "_x"}, 32'(cursor_x), 32'(x));
        checkOutput({name, "_y"}, 32'(cursor_y), 32'(y));
    endtask

    initial begin
        #5_000_000;
        checkCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        finishRun();
    end

    initial begin
        int w0;
        int b0;
        logic [7:0] ch;
        logic       doAttr;
        int         r;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; attr_we = 1'b0; attr_data = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkCursor("reset", 0, 0);
        checkOutput("reset_we", vram_we, 0);
        checkOutput("reset_addr", vram_addr, 0);
        checkOutput("reset_wdata", vram_wdata, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready", in_ready, 0);
        rst_n = 1'b1;

        // First write
        applyStimulus(8'h41, 1'b1, 8'h07);
        checkOutput("first_we", vram_we, 1);
        checkOutput("first_addr", vram_addr, 0);
        checkOutput("first_wdata", vram_wdata, 16'h0741);
        checkOutput("first_ready_low", in_ready, 0);
        @(posedge clk); #1;
        checkOutput("first_we_drop", vram_we, 0);
        checkOutput("first_ready_back", in_ready, 1);
        checkCursor("first_cursor", 1, 0);

        // Table of bytes starting from cursor (1,0), attribute 07
        vecs.push_back('{8'h0A, 1'b0, 16'd0,   7'd0, 5'd1});
        vecs.push_back('{8'h42, 1'b1, 16'd80,  7'd1, 5'd1});
        vecs.push_back('{8'h43, 1'b1, 16'd81,  7'd2, 5'd1});
        vecs.push_back('{8'h44, 1'b1, 16'd82,  7'd3, 5'd1});
        vecs.push_back('{8'h45, 1'b1, 16'd83,  7'd4, 5'd1});
        vecs.push_back('{8'h46, 1'b1, 16'd84,  7'd5, 5'd1});
        vecs.push_back('{8'h0A, 1'b0, 16'd0,   7'd0, 5'd2});
        vecs.push_back('{8'h0A, 1'b0, 16'd0,   7'd0, 5'd3});
        vecs.push_back('{8'h61, 1'b1, 16'd240, 7'd1, 5'd3});
        vecs.push_back('{8'h62, 1'b1, 16'd241, 7'd2, 5'd3});
        vecs.push_back('{8'h63, 1'b1, 16'd242, 7'd3, 5'd3});
        vecs.push_back('{8'h64, 1'b1, 16'd243, 7'd4, 5'd3});
        vecs.push_back('{8'h65, 1'b1, 16'd244, 7'd5, 5'd3});
        vecs.push_back('{8'h08, 1'b0, 16'd0,   7'd4, 5'd3});
        vecs.push_back('{8'h0D, 1'b0, 16'd0,   7'd0, 5'd3});
        vecs.push_back('{8'h0A, 1'b0, 16'd0,   7'd0, 5'd4});
        vecs.push_back('{8'h08, 1'b0, 16'd0,   7'd0, 5'd4});
        vecs.push_back('{8'h7F, 1'b1, 16'd320, 7'd1, 5'd4});
        vecs.push_back('{8'h00, 1'b1, 16'd321, 7'd2, 5'd4});
        vecs.push_back('{8'h0D, 1'b0, 16'd0,   7'd0, 5'd4});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ch, 1'b0, 8'h00);
            checkOutput($sformatf("vec%0d_we", i), vram_we, vecs[i].expWr);
            if (vecs[i].expWr) begin
                checkOutput($sformatf("vec%0d_addr", i), vram_addr, vecs[i].expAddr);
                checkOutput($sformatf("vec%0d_wdata", i), vram_wdata, {8'h07, vecs[i].ch});
            end else begin
                checkOutput($sformatf("vec%0d_ready", i), in_ready, 1);
            end
            waitReady(10);
            checkCursor($sformatf("vec%0d", i), vecs[i].expX, vecs[i].expY);
        end

        // Clear with attribute change on the same cycle as FF
        w0 = writeCnt; b0 = busyCnt;
        applyStimulus(8'h0C, 1'b1, 8'h38);
        checkOutput("clear_busy", busy, 1);
        checkOutput("clear_first_addr", vram_addr, 0);
        checkOutput("clear_first_wdata", vram_wdata, 16'h3820);
        checkOutput("clear_ready_low", in_ready, 0);
        waitReady(3000);
        checkOutput("clear_writes", 32'(writeCnt - w0), 2400);
        checkOutput("clear_busy_cycles", 32'(busyCnt - b0), 2400);
        checkCursor("clear_cursor", 0, 0);
        compareImage("clear_image");

        // Line wrap
        for (int i = 0; i < COLS; i++) begin
            applyStimulus(8'h61 + 8'(i % 26), 1'b0, 8'h00);
            if (i == COLS - 1) checkOutput("wrap_last_addr", vram_addr, 79);
        end
        waitReady(10);
        checkCursor("wrap_cursor", 0, 1);
        applyStimulus(8'h2A, 1'b0, 8'h00);
        checkOutput("wrap_next_addr", vram_addr, 80);
        checkOutput("wrap_next_wdata", vram_wdata, 16'h382A);

        // Scroll (or wrap) from the bottom-right corner
        applyStimulus(8'h0C, 1'b1, 8'h1E);
        for (int rr = 0; rr < ROWS; rr++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!(rr == ROWS - 1 && c == COLS - 1)) applyStimulus(8'h30 + 8'(rr), 1'b0, 8'h00);
            end
        end
        waitReady(10);
        checkCursor("preload_cursor", 79, 29);
        b0 = busyCnt;
        applyStimulus(8'h5A, 1'b0, 8'h00);
        checkOutput("corner_addr", vram_addr, 2399);
        checkOutput("corner_wdata", vram_wdata, 16'h1E5A);
        waitReady(6000);
`ifdef TEXT_CONSOLE_SCROLL_EN
        checkOutput("scroll_busy_cycles", 32'(busyCnt - b0), 4720);
        checkCursor("scroll_cursor", 0, 29);
        checkOutput("scroll_cell0", vram[0], 16'h1E31);
        r = 0;
        for (int i = 2320; i < CELLS; i++) if (vram[i] !== 16'h1E20) r++;
        checkOutput("scroll_blank_row_bad", r, 0);
`else
        checkOutput("noscroll_busy_cycles", 32'(busyCnt - b0), 0);
        checkCursor("noscroll_cursor", 0, 0);
        checkOutput("noscroll_cell0", vram[0], 16'h1E30);
        checkOutput("noscroll_corner", vram[2399], 16'h1E5A);
`endif
        compareImage("scroll_image");

        // Randomized stream against the model
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) ch = 8'h0A;
            else if (r < 8) ch = 8'h0D;
            else if (r < 13) ch = 8'h08;
            else if (r < 14) ch = 8'h0C;
            else begin
                ch = 8'($urandom_range(0, 255));
                if (ch == 8'h08 || ch == 8'h0A || ch == 8'h0C || ch == 8'h0D) ch = 8'h41;
            end
            doAttr = ($urandom_range(0, 9) == 0);
            applyStimulus(ch, doAttr, 8'($urandom));
            waitReady(6000);
            checkCursor($sformatf("rand%0d", n), refX, refY);
        end
        compareImage("random_image");

        // Reset in the middle of a long operation
`ifdef TEXT_CONSOLE_SCROLL_EN
        while (refY < ROWS - 1) begin
            applyStimulus(8'h0A, 1'b0, 8'h00);
            waitReady(6000);
        end
        applyStimulus(8'h0A, 1'b0, 8'h00);
`else
        applyStimulus(8'h0C, 1'b0, 8'h00);
`endif
        repeat (100) @(posedge clk);
        #1;
        checkOutput("midop_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkCursor("midreset", 0, 0);
        checkOutput("midreset_we", vram_we, 0);
        checkOutput("midreset_addr", vram_addr, 0);
        checkOutput("midreset_wdata", vram_wdata, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_reset_ready", in_ready, 1);

        finishRun();
    end

endmodule
